// File: rtl/slave_ram_if.sv
// slave_ram_if: pipelined Wishbone B4 bus bundle.
// Signal names follow the responder's point of view.
interface slave_ram_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;
  logic                  stall_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/slave_ram.sv
// slave_ram: pipelined Wishbone B4 responder over synchronous RAM.
// Define SLAVE_RAM_ERR_EN to answer out-of-range addresses with err_o.
module slave_ram #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_DEPTH_LOG2 = 8,
  parameter int LATENCY        = 2,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic       clk_i,
  input  logic       reset_i,
  slave_ram_if.slave bus
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int RW =
    (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;

  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  logic [MEM_DEPTH_LOG2-1:0] idx;
  logic                      accept;
  logic                      is_err;
  logic                      wr_en;
  logic [DATA_WIDTH-1:0]     rd_d;

  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [LATENCY-1:0]    err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q [LATENCY];

  logic [RW-1:0] ref_q, ref_d;
  logic          ref_last;

  assign idx = bus.adr_i[MEM_DEPTH_LOG2-1:0];

`ifdef SLAVE_RAM_ERR_EN
  assign is_err = (bus.adr_i >> MEM_DEPTH_LOG2) != '0;
`else
  logic unused_hi;
  assign is_err    = 1'b0;
  assign unused_hi = ^(bus.adr_i >> MEM_DEPTH_LOG2);
`endif

  assign ref_last = (REFRESH_PERIOD != 0) &&
                    (ref_q == RW'(REFRESH_PERIOD - 1));
  assign bus.stall_o = ref_last;

  assign accept = bus.cyc_i & bus.stb_i & ~ref_last;
  assign wr_en  = accept & bus.we_i & ~is_err;
  // Writes and errored reads carry zero so dat_o stays bus-OR clean.
  assign rd_d   = (bus.we_i | is_err) ? '0 : mem_q[idx];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[idx] <= bus.dat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    dat_q[0] <= rd_d;
    for (int i = 1; i < LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_comb begin
    vld_d = '0;
    err_d = '0;
    err_d[0] = is_err;
    for (int i = 1; i < LATENCY; i++) begin
      err_d[i] = err_q[i-1];
    end
    if (bus.cyc_i) begin
      vld_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  always_comb begin
    ref_d = '0;
    if (REFRESH_PERIOD != 0 && !ref_last) begin
      ref_d = ref_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q <= '0;
      err_q <= '0;
      ref_q <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      ref_q <= ref_d;
    end
  end

  assign bus.ack_o = vld_q[LATENCY-1] & ~err_q[LATENCY-1]
                   & bus.cyc_i;
`ifdef SLAVE_RAM_ERR_EN
  assign bus.err_o = vld_q[LATENCY-1] & err_q[LATENCY-1]
                   & bus.cyc_i;
`else
  assign bus.err_o = 1'b0;
`endif
  assign bus.dat_o = bus.ack_o ? dat_q[LATENCY-1] : '0;

endmodule

// File: tb/tb_slave_ram.sv
// tb_slave_ram: directed checks of slave_ram on two configs.
// bus_a: LATENCY=2 no refresh; bus_b: LATENCY=4 refresh 8.
module tb_slave_ram;

  localparam int AW = 16;
  localparam int DW = 16;
`ifdef SLAVE_RAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   ecnt = 0;

  always #5 clk = ~clk;

  slave_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  slave_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  slave_ram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(8),
    .LATENCY(2), .REFRESH_PERIOD(0)
  ) u_a (.clk_i(clk), .reset_i(rst), .bus(bus_a));

  slave_ram #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH_LOG2(8),
    .LATENCY(4), .REFRESH_PERIOD(8)
  ) u_b (.clk_i(clk), .reset_i(rst), .bus(bus_b));

  // edges since reset release, for the refresh model
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  typedef struct {
    bit          rst, cyc, stb, we;
    logic [15:0] adr, wd;
    bit          ack, err;
    logic [15:0] rd;
  } vec_t;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(
    bit r, bit c, bit s, bit w,
    logic [15:0] a, logic [15:0] d,
    bit ak, bit er, logic [15:0] rd
  );
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.we = w;
    v.adr = a; v.wd = d;
    v.ack = ak; v.err = er; v.rd = rd;
    return v;
  endfunction

  task automatic drive(input bit b, input bit c, input bit s,
                       input bit w, input logic [15:0] a,
                       input logic [15:0] d);
    bus_a.cyc_i = !b && c;
    bus_a.stb_i = !b && s;
    bus_a.we_i  = w;
    bus_a.adr_i = a;
    bus_a.dat_i = d;
    bus_b.cyc_i = b && c;
    bus_b.stb_i = b && s;
    bus_b.we_i  = w;
    bus_b.adr_i = a;
    bus_b.dat_i = d;
  endtask

  // one bus cycle: apply inputs, check outputs, cross the edge
  task automatic step(input bit b, input vec_t v,
                      input string tag);
    logic sb;
    rst = v.rst;
    drive(b, v.cyc, v.stb, v.we, v.adr, v.wd);
    #1;
    sb = b && ((ecnt % 8) == 7);
    if (b) begin
      chk({tag, "_ack"}, 32'(bus_b.ack_o), 32'(v.ack));
      chk({tag, "_err"}, 32'(bus_b.err_o), 32'(v.err));
      chk({tag, "_dat"}, 32'(bus_b.dat_o), 32'(v.rd));
      chk({tag, "_stl"}, 32'(bus_b.stall_o), 32'(sb));
    end else begin
      chk({tag, "_ack"}, 32'(bus_a.ack_o), 32'(v.ack));
      chk({tag, "_err"}, 32'(bus_a.err_o), 32'(v.err));
      chk({tag, "_dat"}, 32'(bus_a.dat_o), 32'(v.rd));
      chk({tag, "_stl"}, 32'(bus_a.stall_o), 32'(sb));
    end
    @(posedge clk);
    #1;
  endtask

  // idle bus_b until the next 7 edges are stall-free
  task automatic align_b(input string tag);
    int n = 0;
    while ((ecnt % 8) != 0 && n < 16) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(posedge clk);
      #1;
      n++;
    end
    if ((ecnt % 8) != 0) chk({tag, "_align"}, 32'(ecnt % 8), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   nst, nacc, nack;
    logic [15:0] rdx;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ack", 32'(bus_a.ack_o), 32'd0);
    chk("rst_a_err", 32'(bus_a.err_o), 32'd0);
    chk("rst_a_dat", 32'(bus_a.dat_o), 32'd0);
    chk("rst_a_stl", 32'(bus_a.stall_o), 32'd0);
    chk("rst_b_ack", 32'(bus_b.ack_o), 32'd0);
    chk("rst_b_err", 32'(bus_b.err_o), 32'd0);
    chk("rst_b_dat", 32'(bus_b.dat_o), 32'd0);
    chk("rst_b_stl", 32'(bus_b.stall_o), 32'd0);

    // write then read-after-write on LATENCY=2
    step(0, mk(0,1,1,1,16'h0005,16'h1234,0,0,16'h0), "a1_1");
    step(0, mk(0,1,1,0,16'h0005,16'h0000,0,0,16'h0), "a1_2");
    step(0, mk(0,1,0,0,16'h0000,16'h0000,1,0,16'h0), "a1_3");
    step(0, mk(0,1,0,0,16'h0000,16'h0000,1,0,16'h1234), "a1_4");
    step(0, mk(0,1,0,0,16'h0000,16'h0000,0,0,16'h0), "a1_5");

    // preload 0..7 with addr*3, then 8 back-to-back reads
    for (int c = 1; c <= 18; c++) begin
      rdx = (c >= 11) ? 16'(3 * (c - 11)) : 16'h0;
      v = mk(0, 1, c <= 16, c <= 8,
             16'((c <= 8) ? c - 1 : c - 9),
             16'(3 * (c - 1)),
             c >= 3, 0, rdx);
      step(0, v, $sformatf("a2_%0d", c));
    end

    // upper address bits: alias or error
    step(0, mk(0,1,1,1,16'h0105,16'hBEEF,0,0,16'h0), "a3_1");
    step(0, mk(0,1,1,0,16'h0005,16'h0000,0,0,16'h0), "a3_2");
    step(0, mk(0,1,0,0,16'h0000,16'h0000,
               !ERR_EN,ERR_EN,16'h0), "a3_3");
    step(0, mk(0,1,0,0,16'h0000,16'h0000,1,0,
               ERR_EN ? 16'h000F : 16'hBEEF), "a3_4");
    step(0, mk(0,1,0,0,16'h0000,16'h0000,0,0,16'h0), "a3_5");

    // refresh back-pressure under continuous requests
    nst = 0; nacc = 0; nack = 0;
    for (int c = 0; c < 36; c++) begin
      drive(1'b1, 1'b1, c < 32, 1'b0, 16'h0010, 16'h0);
      #1;
      if (c < 32) begin
        if (bus_b.stall_o) nst++;
        else               nacc++;
      end
      if (bus_b.ack_o) nack++;
      chk($sformatf("ref_stl_%0d", c),
          32'(bus_b.stall_o), 32'((ecnt % 8) == 7));
      @(posedge clk);
      #1;
    end
    chk("ref_nstall", 32'(nst), 32'd4);
    chk("ref_nacc", 32'(nacc), 32'd28);
    chk("ref_nack", 32'(nack), 32'd28);

    // abort: three reads dropped, earlier write still lands
    align_b("ab");
    step(1, mk(0,1,1,1,16'h0020,16'h5A5A,0,0,16'h0), "ab_1");
    step(1, mk(0,1,1,0,16'h0001,16'h0000,0,0,16'h0), "ab_2");
    step(1, mk(0,1,1,0,16'h0002,16'h0000,0,0,16'h0), "ab_3");
    step(1, mk(0,1,1,0,16'h0003,16'h0000,0,0,16'h0), "ab_4");
    step(1, mk(0,0,0,0,16'h0000,16'h0000,0,0,16'h0), "ab_5");
    step(1, mk(0,1,1,0,16'h0020,16'h0000,0,0,16'h0), "ab_6");
    for (int c = 7; c <= 11; c++) begin
      v = mk(0,1,0,0,16'h0,16'h0, c == 10, 0,
             (c == 10) ? 16'h5A5A : 16'h0);
      step(1, v, $sformatf("ab_%0d", c));
    end

    // reset with two reads in flight; refresh restarts
    align_b("rs");
    step(1, mk(0,1,1,0,16'h0001,16'h0000,0,0,16'h0), "rs_1");
    step(1, mk(0,1,1,0,16'h0002,16'h0000,0,0,16'h0), "rs_2");
    step(1, mk(1,1,0,0,16'h0000,16'h0000,0,0,16'h0), "rs_3");
    for (int c = 4; c <= 12; c++) begin
      v = mk(0,1,0,0,16'h0,16'h0,0,0,16'h0);
      step(1, v, $sformatf("rs_%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
